// File: rtl/isqrt_pipe_if.sv
// isqrt_pipe_if: operand/result bundle between the issuing FSM and the square-root pipeline
interface isqrt_pipe_if;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;
  modport master (output x_vld, x, input y_vld, y);
  modport slave (input x_vld, x, output y_vld, y);
endinterface

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined floor(sqrt(x)) of a 32-bit radicand, N_STAGES cycles of latency
module isqrt_pipe #(
  parameter int N_STAGES = 4
) (
  input logic         clk,
  input logic         rst,
  isqrt_pipe_if.slave bus
);
  localparam int ITER = 16 / N_STAGES;
  if (N_STAGES < 1 || N_STAGES > 16 || (16 % N_STAGES) != 0) begin : g_bad_n_stages
    $error("isqrt_pipe: N_STAGES must be 1, 2, 4, 8 or 16");
  end
  typedef struct packed {
    logic [31:0] xs;
    logic [18:0] rem;
    logic [15:0] root;
  } st_t;
  function automatic st_t step(input st_t s);
    st_t o;
    logic [18:0] w_r;
    logic [18:0] w_t;
    o = s;
    for (int i = 0; i < ITER; i++) begin
      w_r = {o.rem[16:0], o.xs[31:30]};
      w_t = {1'b0, o.root, 2'b01};
      o.xs = {o.xs[29:0], 2'b00};
      o.rem = (w_r >= w_t) ? w_r - w_t : w_r;
      o.root = {o.root[14:0], w_r >= w_t};
    end
    return o;
  endfunction
  st_t  r_st [N_STAGES];
  logic r_vld [N_STAGES];
  st_t  w_in [N_STAGES];
  logic w_vin [N_STAGES];
  always_comb begin
    w_in[0] = '{xs: bus.x, rem: 19'd0, root: 16'd0};
    w_vin[0] = bus.x_vld;
    for (int k = 1; k < N_STAGES; k++) begin
      w_in[k] = r_st[k-1];
      w_vin[k] = r_vld[k-1];
    end
  end
  // data loads unconditionally; only the valid chain is reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_STAGES; k++) begin
      r_st[k] <= step(w_in[k]);
      r_vld[k] <= !rst && w_vin[k];
    end
  end
  assign bus.y = r_st[N_STAGES-1].root;
  assign bus.y_vld = r_vld[N_STAGES-1];
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb_isqrt_pipe: random and corner stimulus into five pipeline depths at once, scoreboarded against an arithmetic sqrt model
module tb_isqrt_pipe;
  localparam int NI = 5;
  typedef struct {
    int          due;
    logic [15:0] y;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld_a [NI];
  logic [15:0] y_a [NI];
  exp_t        q [NI][$];
  exp_t        m_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int ns_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : (i == 3) ? 8 : 16;
  endfunction
  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint xv = longint'({32'd0, v});
    longint y = longint'($sqrt(real'(xv)));
    while (y * y > xv) y--;
    while ((y + 1) * (y + 1) <= xv) y++;
    return 16'(y);
  endfunction
  for (genvar g = 0; g < NI; g++) begin : g_dut
    isqrt_pipe_if ifc ();
    assign ifc.x_vld = x_vld;
    assign ifc.x = x;
    assign y_vld_a[g] = ifc.y_vld;
    assign y_a[g] = ifc.y;
    isqrt_pipe #(.N_STAGES(ns_of(g))) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
    );
  end
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (q[i].size() > 0 && q[i][0].due == cyc) begin
          m_e = q[i].pop_front();
          if (y_vld_a[i] !== 1'b1 || y_a[i] !== m_e.y) begin
            errors++;
            $display("FAIL result N=%0d cyc=%0d: got y_vld=%b y=%h, expected y_vld=1 y=%h",
                     ns_of(i), cyc, y_vld_a[i], y_a[i], m_e.y);
          end
        end else if (y_vld_a[i] !== 1'b0) begin
          errors++;
          $display("FAIL idle N=%0d cyc=%0d: got y_vld=%b, expected y_vld=0", ns_of(i), cyc, y_vld_a[i]);
        end
      end
    end
  end
  task automatic issue(input logic v, input logic [31:0] val);
    x_vld = v;
    x = val;
    if (v && !rst)
      for (int i = 0; i < NI; i++) q[i].push_back('{due: cyc + ns_of(i), y: ref_sqrt(val)});
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) issue(1'b0, $urandom);
  endtask
  task automatic pulse_rst(input logic v, input logic [31:0] val);
    rst = 1'b1;
    for (int i = 0; i < NI; i++)
      while (q[i].size() > 0 && q[i][$].due > cyc) void'(q[i].pop_back());
    issue(v, val);
    rst = 1'b0;
  endtask
  function automatic logic [31:0] rand_x();
    int unsigned s;
    int unsigned sel = $urandom_range(0, 3);
    s = $urandom_range(0, 65535);
    if (sel == 0) return 32'($urandom_range(0, 65535));
    if (sel == 1) return s * s;
    if (sel == 2) return (s == 0) ? 32'd0 : s * s - 1;
    return $urandom;
  endfunction
  initial begin
    logic [31:0] corners [9];
    logic        pat [6];
    int          n;
    corners = '{32'd0, 32'd1, 32'd3, 32'd4, 32'd144, 32'hFFFF_FFFF,
                32'hFFFE_0001, 32'hFFFE_0000, 32'hFFFF_FFFE};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    x_vld = 1'b1;
    x = 32'd5;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    issue(1'b1, 32'd77);
    issue(1'b1, 32'd99);
    rst = 1'b0;
    foreach (corners[k]) begin
      issue(1'b1, corners[k]);
      idle(17);
    end
    issue(1'b1, 32'd9);
    issue(1'b1, 32'd16);
    issue(1'b1, 32'd26);
    idle(20);
    issue(1'b1, 32'd100);
    issue(1'b1, 32'd200);
    issue(1'b1, 32'd300);
    pulse_rst(1'b1, 32'd400);
    issue(1'b1, 32'd49);
    idle(20);
    n = 0;
    while (n < 10000) begin
      foreach (pat[j]) begin
        issue(pat[j], rand_x());
        if (pat[j]) n++;
      end
    end
    for (int k = 0; k < 200; k++) issue(1'($urandom), rand_x());
    issue(1'b1, 32'd1234);
    issue(1'b1, 32'd5678);
    pulse_rst(1'b0, 32'd0);
    issue(1'b1, 32'd49);
    idle(20);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL drain N=%0d: %0d results outstanding, expected 0", ns_of(i), q[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/isqrt_pipe.md
Name: isqrt_pipe

Overview:
- Pipelined integer square root unit: y = floor(sqrt(x)) for 32-bit unsigned x, 16-bit result.
- Single shared instance sits in formula_1_pipe_aware_fsm_top, directly downstream of formula_1_pipe_aware_fsm (consumes isqrt_x/isqrt_x_vld, returns isqrt_y/isqrt_y_vld).
- Fully pipelined: one new operand per clock, fixed latency N_STAGES; the FSM relies on back-to-back issue of three operands and in-order return.

Parameters:
- N_STAGES, 4, number of register stages = latency in cycles; legal values 1, 2, 4, 8, 16 (must divide 16); any other value is a static elaboration error.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- x_vld  input  1  operand valid, one operand accepted per cycle when high
- x  input  32  unsigned radicand
- y_vld  output  1  result valid, single-cycle pulse per accepted operand
- y  output  16  floor(sqrt(x)) of the matching operand

Behaviour:
- No backpressure: no ready signal; every cycle with x_vld=1 is accepted unconditionally.
- Algorithm: 16 digit iterations, i = 15 down to 0, on state {xs[31:0], rem[18:0], root[15:0]}. Initial state: xs=x, rem=0, root=0.
- One iteration: rem' = (rem<<2) | xs[31:30]; xs' = xs<<2; trial = (root<<2) | 1, zero-extended to 19 bits; if rem' >= trial then rem'' = rem' - trial and root' = (root<<1)|1, else rem'' = rem' and root' = root<<1.
- rem width is 19 bits so no truncation occurs at x = 0xFFFFFFFF. root is 16 bits. The final rem is discarded.
- Stage k (k = 0..N_STAGES-1) combinationally performs 16/N_STAGES iterations on the output of stage k-1. Stage 0 takes its input from the port. Stage k then registers {xs, rem, root, vld}.
- Output: y = root of the last stage register; y_vld = vld of the last stage register.
- Latency: operand presented with x_vld=1 in cycle t produces y_vld=1 with the correct y in cycle t+N_STAGES, exactly.
- Ordering: results return strictly in issue order. Gaps in x_vld appear as identical gaps in y_vld.
- Throughput: 1 result per cycle for any x_vld pattern, including continuous high.
- Reset:
  - rst=1 clears every stage vld bit on the same clock edge, so y_vld=0 from the cycle after rst is sampled.
  - Operands in flight are dropped and never produce y_vld.
  - Data registers (xs, rem, root) are not reset. y is don't-care while y_vld=0.
  - x_vld=1 in a cycle where rst=1 is ignored.
  - First accepted operand is the one with x_vld=1 in the first cycle with rst=0.
- Data registers load every cycle, regardless of vld. Only vld gates meaning.
- No state machine. Control is the N_STAGES-deep valid shift register only.
- N_STAGES=16: one iteration per stage. N_STAGES=1: fully combinational 16-iteration chain into a single register, latency 1.

Test Plan:
- Corners, N_STAGES=4: single pulses x=0, 1, 3, 4, 144, 0xFFFFFFFF -> y = 0, 1, 1, 2, 12, 0xFFFF respectively. Each y_vld pulse is exactly 4 cycles after its x_vld, one cycle wide.
- Perfect squares and neighbours: x = 65535^2 = 0xFFFE0001, that value minus 1, and 0xFFFFFFFE -> y = 0xFFFF, 0xFFFE, 0xFFFF. No overflow in rem.
- Back-to-back stream: x_vld held high 3 cycles with x = 9, 16, 26 (FSM pattern) -> y_vld high 3 consecutive cycles starting at t+4, y = 3, 4, 5 in order.
- Gapped traffic: x_vld pattern 1,0,1,1,0,1 with 10000 random x -> y_vld reproduces the pattern shifted by N_STAGES. Each y matches a reference floor-sqrt model with no reordering.
- Reset mid-flight: issue x = 100, 200, 300 on consecutive cycles, assert rst for 1 cycle on the cycle after the last issue -> no y_vld for any of them. x = 49 issued after reset yields y = 7 exactly N_STAGES cycles later.
- Parameter sweep: repeat the random test with N_STAGES = 1, 2, 8, 16 -> latency equals N_STAGES and results match the model. N_STAGES = 3 fails elaboration.
